bp_profiler_snapshot_streamer: RTL and testbench

//  Sits downstream of the commit/stall profiler counter bank. On a host request or

---
 rtl/bp_profiler_snapshot_streamer_if.sv | 11 +
 rtl/bp_profiler_snapshot_streamer.sv | 126 ++++++++++++
 tb/tb_bp_profiler_snapshot_streamer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_profiler_snapshot_streamer_if.sv
// Valid/ready stream carrying snapshot words from the streamer to the PS-facing FIFO.
interface bp_profiler_snapshot_streamer_if #(
    parameter int unsigned width_p = 32
);
    logic [width_p-1:0] data;
    logic               v;
    logic               ready;

    modport master (output data, output v, input ready);
    modport slave  (input data, input v, output ready);
endinterface

// File: rtl/bp_profiler_snapshot_streamer.sv
// Captures the profiler counter bank into a shadow array on a host request or timer tick,
// then streams one header word plus every captured counter over a valid/ready interface.
module bp_profiler_snapshot_streamer #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned num_counters_p = 65
) (
    input  logic                                    clk_i,
    input  logic                                    aresetn_i,
    input  logic                                    en_i,
    input  logic [width_p-1:0]                      interval_i,
    input  logic                                    sample_req_i,
    input  logic [num_counters_p-1:0][width_p-1:0]  counters_i,
    bp_profiler_snapshot_streamer_if.master         strm,
    output logic                                    busy_o,
    output logic [width_p-17:0]                     seq_o,
    output logic [width_p-1:0]                      drop_cnt_o
);

    localparam int unsigned idx_w = (num_counters_p > 1) ? $clog2(num_counters_p) : 1;
    localparam int unsigned seq_w = width_p - 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] STRM = 2'd2;

    logic [1:0]                               state_q, state_n;
    logic [idx_w-1:0]                         idx_q, idx_n;
    logic [width_p-1:0]                       data_q, data_n;
    logic                                     act_q;
    logic [seq_w-1:0]                         seq_q;
    logic [width_p-1:0]                       drop_q;
    logic [width_p-1:0]                       timer_q;
    logic [num_counters_p-1:0][width_p-1:0]   snap_q;

    logic tmr_on, fire, trigger, hs, capture, seq_inc, drop_inc, last;

    // Timer free-runs while enabled; >= lets a shrinking interval fire immediately.
    assign tmr_on   = en_i & (interval_i != '0);
    assign fire     = tmr_on & (timer_q >= (interval_i - width_p'(1)));
    assign trigger  = en_i & (sample_req_i | fire);
    assign hs       = act_q & strm.ready;
    assign last     = (idx_q == idx_w'(num_counters_p - 1));
    assign drop_inc = trigger & (state_q != IDLE);

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        data_n  = data_q;
        capture = 1'b0;
        seq_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_n = HDR;
                    capture = 1'b1;
                    data_n  = {seq_q, 16'(num_counters_p)};
                end
            end
            HDR: begin
                if (hs) begin
                    state_n = STRM;
                    idx_n   = '0;
                    data_n  = snap_q[0];
                end
            end
            STRM: begin
                if (hs) begin
                    if (last) begin
                        state_n = IDLE;
                        seq_inc = 1'b1;
                    end else begin
                        idx_n  = idx_q + idx_w'(1);
                        data_n = snap_q[idx_n];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            data_q  <= data_n;
            act_q   <= (state_n != IDLE);
        end
    end

    // Shadow array, snapshot sequence number, drop counter and periodic timer.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            snap_q  <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            timer_q <= '0;
        end else begin
            if (capture) begin
                snap_q <= counters_i;
            end
            if (seq_inc) begin
                seq_q <= seq_q + seq_w'(1);
            end
            if (drop_inc && (drop_q != '1)) begin
                drop_q <= drop_q + width_p'(1);
            end
            if (!tmr_on || fire) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + width_p'(1);
            end
        end
    end

    assign strm.data  = data_q;
    assign strm.v     = act_q;
    assign busy_o     = act_q;
    assign seq_o      = seq_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_bp_profiler_snapshot_streamer.sv
// Bench for the snapshot streamer: directed vector table, corner sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_bp_profiler_snapshot_streamer;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic                    clk = 1'b0;
    logic                    aresetn;
    logic                    en;
    logic [W-1:0]            interval;
    logic                    req;
    logic [N-1:0][W-1:0]     cnt;
    logic                    busy;
    logic [W-17:0]           seq;
    logic [W-1:0]            drop;

    bp_profiler_snapshot_streamer_if #(.width_p(W)) s ();

    bp_profiler_snapshot_streamer #(.width_p(W), .num_counters_p(N)) dut (
        .clk_i        (clk),
        .aresetn_i    (aresetn),
        .en_i         (en),
        .interval_i   (interval),
        .sample_req_i (req),
        .counters_i   (cnt),
        .strm         (s.master),
        .busy_o       (busy),
        .seq_o        (seq),
        .drop_cnt_o   (drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a snapshot is just a queue of words still to be delivered.
    logic [W-1:0] m_q[$];
    int unsigned  m_seq;
    logic [W-1:0] m_drop;
    longint       m_tmr;

    task automatic model_reset();
        m_q.delete();
        m_seq  = 0;
        m_drop = '0;
        m_tmr  = 0;
    endtask

    task automatic model_step();
        bit fire, trig, idle;
        fire = en && (interval != 0) && (m_tmr >= longint'(interval) - 1);
        trig = en && (req || fire);
        idle = (m_q.size() == 0);
        if (!idle && s.ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_seq = (m_seq + 1) % 65536;
        end
        if (trig) begin
            if (idle) begin
                m_q.push_back({16'(m_seq), 16'(N)});
                for (int k = 0; k < N; k++) m_q.push_back(cnt[k]);
            end else if (m_drop != 32'hFFFF_FFFF) begin
                m_drop = m_drop + 1;
            end
        end
        if (en && interval != 0) m_tmr = fire ? 0 : m_tmr + 1;
        else m_tmr = 0;
    endtask

    task automatic model_check();
        check("v", 64'(s.v), 64'(m_q.size() != 0));
        check("busy", 64'(busy), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check("data", 64'(s.data), 64'(m_q[0]));
        check("seq", 64'(seq), 64'(m_seq));
        check("drop", 64'(drop), 64'(m_drop));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic base_cnt();
        for (int k = 0; k < N; k++) cnt[k] = W'(5 + k);
    endtask

    typedef struct {
        logic        req;
        logic        ready;
        logic        exp_v;
        logic [31:0] exp_data;
        logic [15:0] exp_seq;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Snapshot with ready held high, then a second one with a 3-cycle stall on word 6.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'd5,         16'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd6,         16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd7,         16'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'd8,         16'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'd0,         16'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h0001_0004, 16'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'd5,         16'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'd6,         16'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'd6,         16'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'd6,         16'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'd6,         16'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 32'd7,         16'd1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 32'd8,         16'd1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 32'd0,         16'd2};

        en = 1'b0; interval = '0; req = 1'b0; s.ready = 1'b1;
        base_cnt();
        reset_dut();

        check("rst_v", 64'(s.v), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_seq", 64'(seq), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_data", 64'(s.data), 64'd0);

        // Directed table; live counters are scrambled after each capture.
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            req     = tbl[i].req;
            s.ready = tbl[i].ready;
            if (tbl[i].req) base_cnt();
            else for (int k = 0; k < N; k++) cnt[k] = $urandom;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_v", i), 64'(s.v), 64'(tbl[i].exp_v));
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].exp_v));
            check($sformatf("tbl%0d_seq", i), 64'(seq), 64'(tbl[i].exp_seq));
            if (tbl[i].exp_v) check($sformatf("tbl%0d_data", i), 64'(s.data), 64'(tbl[i].exp_data));
        end
        check("tbl_drop", 64'(drop), 64'd0);

        // Requests on the capture cycle, two cycles later and on the final handshake.
        req = 1'b0; s.ready = 1'b1; base_cnt();
        reset_dut();
        en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req = (c == 0) || (c == 2) || (c == 5);
            cycle();
        end
        check("drop_cnt", 64'(drop), 64'd2);
        check("drop_seq", 64'(seq), 64'd1);
        check("drop_idle", 64'(s.v), 64'd0);

        // Periodic timer: three periods of 20 cycles give three snapshots.
        req = 1'b0; en = 1'b0;
        reset_dut();
        en = 1'b1; interval = 32'd20;
        repeat (70) cycle();
        check("per_seq", 64'(seq), 64'd3);
        check("per_drop", 64'(drop), 64'd0);

        // Reset asserted mid-stream at idx=2.
        en = 1'b0; interval = '0;
        reset_dut();
        en = 1'b1; req = 1'b1; base_cnt();
        cycle();
        req = 1'b0;
        repeat (3) cycle();
        check("mid_data", 64'(s.data), 64'd7);
        aresetn = 1'b0;
        #1;
        check("mid_rst_v", 64'(s.v), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        cycle();
        check("post_rst_seq", 64'(seq), 64'd0);
        check("post_rst_v", 64'(s.v), 64'd0);

        // Randomized traffic against the reference model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 3))
                    0: interval = '0;
                    1: interval = 32'd3;
                    2: interval = 32'd7;
                    default: interval = 32'($urandom_range(1, 30));
                endcase
            end
            en      = ($urandom_range(0, 99) < 90);
            req     = ($urandom_range(0, 99) < 10);
            s.ready = ($urandom_range(0, 99) < 70);
            for (int k = 0; k < N; k++) cnt[k] = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
